pad_reader: RTL and testbench
=============================

Name: pad_reader

Overview:
- Polls a serial NES-style gamepad and produces the level-sensitive movement commands (right, left, jump, squat, defend) that drive the player-motion logic.
- Generates the pad latch/clock waveform and shifts in 8 active-low button bits.
- Decodes the bits into command levels, updated atomically once per poll frame.
- Sits between the board-level pad pins and the player-motion block; one instance per player.

Parameters:
- HALF, 300: pad_clk half-period in clk cycles (6 us at 50 MHz); legal range >= 2.
- POLL_PERIOD, 833333: clk cycles between frame starts (60 Hz at 50 MHz); must be >= 17*HALF + 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pad_data  in  1  serial button data from pad; active-low (0 = pressed); asynchronous to clk
- pad_latch  out  1  pad latch strobe, registered
- pad_clk  out  1  pad shift clock, registered
- buttons  out  8  decoded buttons, 1 = pressed; bit order [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
- frame_valid  out  1  one-cycle pulse when buttons and commands update
- right  out  1  move-right command level
- left  out  1  move-left command level
- jump  out  1  jump command level
- squat  out  1  squat command level
- defend  out  1  defend command level

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; poll counter 0; shift register 0; synchronizer flops 1 (released state).
- Input synchronization: pad_data passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Poll counter: free-running, 0..POLL_PERIOD-1, wraps. A frame starts when the counter is 0 and the FSM is IDLE, so the first frame starts on the first clk edge after reset release.
- FSM states and transitions:
  - IDLE: pad_latch=0, pad_clk=0. Go to LATCH at frame start.
  - LATCH: pad_latch=1 for 2*HALF cycles, then go to LOW with bit index k=0.
  - LOW: pad_clk=0 for HALF cycles. On the last cycle, sample inverted synced pad_data into buttons bit k. If k=7, go to DONE; else go to HIGH.
  - HIGH: pad_clk=1 for HALF cycles, then k=k+1 and go to LOW.
  - DONE: one cycle. Update outputs, pulse frame_valid, return to IDLE.
- Frame length: LATCH through the last LOW is 17*HALF cycles; the full frame including DONE is 17*HALF+1 cycles.
- Output update: buttons and all command outputs are registered and change only in DONE. They hold between frames; there are no partial updates.
- Command decode (from the newly captured bits):
  - right = Right & ~Left; left = Left & ~Right. Both pressed gives neither.
  - jump = A | Up.
  - squat = Down & ~(A | Up), so jump wins over squat.
  - defend = B.
  - Select and Start appear only on buttons.
- frame_valid is high exactly one cycle per frame, in the same cycle the new values appear.
- Disconnected pad (pull-up, reads 1): all buttons read 0 and all commands are 0.
- pad_data changing mid-frame: only the synced value at each sample point matters.
- Reset mid-frame: immediately returns to IDLE with all outputs 0. The next frame starts on the first edge after release.

Test Plan:
- Reset, HALF=2, POLL_PERIOD=64, pad_data held 1:
  - pad_latch high cycles 1-4 after release; 7 pad_clk pulses each 2 cycles high.
  - frame_valid pulses once at cycle 35; buttons=0x00; all commands 0.
  - Next latch at cycle 65.
- Pad model drives Right only (bit7=0, rest 1) -> buttons=0x80, right=1, others 0, from the frame_valid cycle until the next frame.
- Left+Right+Down+A pressed -> buttons=0xE1; right=0, left=0, jump=1, squat=0.
- B+Down pressed, next frame released -> first frame defend=1, squat=1, buttons=0x22; second frame all 0.
- Assert rst_n=0 during HIGH of bit 3 with Right pressed in the previous frame -> all outputs 0 immediately; after release, a fresh latch starts and no frame_valid occurs for the aborted frame.
- pad_data toggling every cycle except stable windows around sample points, with a pattern encoding 0x5A -> buttons=0x5A, proving sampling only on the last LOW cycle.

Source files
------------

// File: rtl/pad_reader.sv
// Serial NES-style gamepad poller.
// Produces per-frame button bits and player movement command levels.
module pad_reader #(
  parameter int HALF        = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       frame_valid,
  output logic       right,
  output logic       left,
  output logic       jump,
  output logic       squat,
  output logic       defend
);

  localparam int TW = $clog2(2 * HALF);
  localparam int PW = $clog2(POLL_PERIOD);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   tmr;
  logic [TW-1:0]   tmr_n;
  logic [2:0]      k;
  logic [2:0]      k_n;
  logic [7:0]      shreg;
  logic [7:0]      shreg_n;
  logic [PW-1:0]   poll;
  logic            sync1;
  logic            sync2;
  logic            jump_n;

  always_comb begin
    state_n = state;
    tmr_n   = tmr + 1'b1;
    k_n     = k;
    shreg_n = shreg;
    unique case (state)
      IDLE: begin
        tmr_n = '0;
        if (poll == '0) state_n = LATCH;
      end
      LATCH: begin
        if (tmr == TW'(2 * HALF - 1)) begin
          state_n = LOW;
          tmr_n   = '0;
          k_n     = 3'd0;
        end
      end
      LOW: begin
        if (tmr == TW'(HALF - 1)) begin
          shreg_n[k] = ~sync2;
          tmr_n      = '0;
          state_n    = (k == 3'd7) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (tmr == TW'(HALF - 1)) begin
          tmr_n   = '0;
          k_n     = k + 3'd1;
          state_n = LOW;
        end
      end
      DONE: begin
        tmr_n   = '0;
        state_n = IDLE;
      end
      default: begin
        tmr_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Jump has priority over squat.
  assign jump_n = shreg_n[0] | shreg_n[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
      k     <= 3'd0;
      shreg <= 8'h00;
      poll  <= '0;
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      k     <= k_n;
      shreg <= shreg_n;
      sync1 <= pad_data;
      sync2 <= sync1;
      if (poll == PW'(POLL_PERIOD - 1)) poll <= '0;
      else poll <= poll + 1'b1;
    end
  end

  // Outputs load on entry to DONE so they are visible in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_latch   <= 1'b0;
      pad_clk     <= 1'b0;
      frame_valid <= 1'b0;
      buttons     <= 8'h00;
      right       <= 1'b0;
      left        <= 1'b0;
      jump        <= 1'b0;
      squat       <= 1'b0;
      defend      <= 1'b0;
    end else begin
      pad_latch   <= (state_n == LATCH);
      pad_clk     <= (state_n == HIGH);
      frame_valid <= (state_n == DONE);
      if (state_n == DONE) begin
        buttons <= shreg_n;
        right   <= shreg_n[7] & ~shreg_n[6];
        left    <= shreg_n[6] & ~shreg_n[7];
        jump    <= jump_n;
        squat   <= shreg_n[5] & ~jump_n;
        defend  <= shreg_n[1];
      end
    end
  end

endmodule

// File: tb/tb_pad_reader.sv
// Bench for pad_reader: pad model, per-cycle frame model and
// directed button patterns.
module tb_pad_reader;

  logic       clk;
  logic       rst_n;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       frame_valid;
  logic       right;
  logic       left;
  logic       jump;
  logic       squat;
  logic       defend;

  pad_reader #(
    .HALF(2),
    .POLL_PERIOD(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pad_data(pad_data),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .buttons(buttons),
    .frame_valid(frame_valid),
    .right(right),
    .left(left),
    .jump(jump),
    .squat(squat),
    .defend(defend)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc;
  int         idx = 8;
  logic [7:0] cur_pat = 8'h00;
  logic       tog = 1'b0;
  logic [7:0] exp_btn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  // Cycle count since reset release; cycle 1 is the first frame start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Pad shift register: latch presents A, each pad_clk rise advances.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) idx <= 0;
    else idx <= idx + 1;
  end

  // Drive pad_data just after each edge.
  initial begin
    pad_data = 1'b1;
    forever begin
      int pos;
      @(posedge clk);
      #1;
      pos = (cyc == 0) ? 0 : ((cyc - 1) % 64) + 1;
      if (tog) begin
        if (pos >= 4 && pos <= 32 && (pos % 4) == 0)
          pad_data = ~cur_pat[(pos - 4) / 4];
        else
          pad_data = cyc[0];
      end else begin
        pad_data = (idx < 8) ? ~cur_pat[idx] : 1'b1;
      end
    end
  end

  function automatic logic [4:0] decode(input logic [7:0] b);
    logic r, l, j, s, d;
    r = b[7] && !b[6];
    l = b[6] && !b[7];
    j = b[0] || b[4];
    s = b[5] && !j;
    d = b[1];
    return {r, l, j, s, d};
  endfunction

  // Frame model: positions within a 64-cycle poll period.
  initial begin
    exp_btn = 8'h00;
    forever begin
      int pos;
      logic e_fv, e_lat, e_clk;
      @(negedge clk);
      e_fv = 1'b0;
      e_lat = 1'b0;
      e_clk = 1'b0;
      if (!rst_n) begin
        exp_btn = 8'h00;
      end else begin
        pos = (cyc == 0) ? 0 : ((cyc - 1) % 64) + 1;
        e_lat = (pos >= 1 && pos <= 4);
        e_clk = (pos >= 7 && pos <= 32 && ((pos - 7) % 4) < 2);
        e_fv = (pos == 35);
        if (e_fv) exp_btn = cur_pat;
      end
      chk("pad_latch", {7'd0, pad_latch}, {7'd0, e_lat});
      chk("pad_clk", {7'd0, pad_clk}, {7'd0, e_clk});
      chk("frame_valid", {7'd0, frame_valid}, {7'd0, e_fv});
      chk("buttons", buttons, exp_btn);
      chk("commands", {3'd0, right, left, jump, squat, defend},
          {3'd0, decode(exp_btn)});
    end
  end

  task automatic at(input int c);
    int i;
    i = 0;
    while (cyc != c && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (cyc != c) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout waiting for cyc %0d: got %0d", c, cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_buttons", buttons, 8'h00);
    chk("rst_fv", {7'd0, frame_valid}, 8'h00);
    rst_n = 1'b1;

    at(1);
    chk("lit_latch_c1", {7'd0, pad_latch}, 8'h01);
    at(5);
    chk("lit_latch_c5", {7'd0, pad_latch}, 8'h00);
    at(35);
    chk("lit_fv_c35", {7'd0, frame_valid}, 8'h01);
    chk("lit_btn_idle", buttons, 8'h00);
    at(36);
    chk("lit_fv_c36", {7'd0, frame_valid}, 8'h00);
    at(40);
    cur_pat = 8'h80;
    at(65);
    chk("lit_latch_c65", {7'd0, pad_latch}, 8'h01);
    at(99);
    chk("lit_btn_right", buttons, 8'h80);
    chk("lit_right", {7'd0, right}, 8'h01);

    at(104);
    cur_pat = 8'hE1;
    at(163);
    chk("lit_btn_e1", buttons, 8'hE1);
    chk("lit_e1_cmd", {3'd0, right, left, jump, squat, defend},
        8'b000_0_0_1_0_0);

    at(168);
    cur_pat = 8'h22;
    at(227);
    chk("lit_btn_22", buttons, 8'h22);
    chk("lit_22_cmd", {3'd0, right, left, jump, squat, defend},
        8'b000_0_0_0_1_1);

    at(232);
    cur_pat = 8'h00;
    at(291);
    chk("lit_btn_rel", buttons, 8'h00);
    chk("lit_rel_cmd", {3'd0, right, left, jump, squat, defend},
        8'h00);

    at(296);
    cur_pat = 8'h80;
    at(355);
    chk("lit_right2", {7'd0, right}, 8'h01);

    at(403);
    rst_n = 1'b0;
    #1;
    chk("lit_midrst_right", {7'd0, right}, 8'h00);
    chk("lit_midrst_btn", buttons, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    at(1);
    chk("lit_relatch", {7'd0, pad_latch}, 8'h01);
    at(34);
    chk("lit_no_fv_c34", {7'd0, frame_valid}, 8'h00);
    at(35);
    chk("lit_btn_after_rst", buttons, 8'h80);

    at(40);
    tog = 1'b1;
    cur_pat = 8'h5A;
    at(99);
    chk("lit_btn_5a", buttons, 8'h5A);
    at(110);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
